// File: rtl/jtcps1_dwnld_sched_pkg.sv
// Shared types and helpers for the ROM-download write scheduler.
// FIFO entries are packed as {bank, mask, data, addr}.
package jtcps1_dwnld_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_st_e;

    // bank(2) + mask(2) + data(8) on top of the word address
    localparam int FIELDS_W = 12;

    function automatic int entry_w(input int aw);
        return aw + FIELDS_W;
    endfunction

endpackage

// File: rtl/jtcps1_dwnld_fifo.sv
// Register-array FIFO holding pending SDRAM byte writes.
// Pointers carry one wrap bit so full and empty are told apart without a counter.
module jtcps1_dwnld_fifo
    import jtcps1_dwnld_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = entry_w(22)
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AB = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AB:0]   wr_ptr;
    logic [AB:0]   rd_ptr;

    // storage write; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AB-1:0]] <= din;
    end

    // pointer update; reset flushes the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AB+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AB+1)'(1);
        end
    end

    assign dout  = mem[rd_ptr[AB-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AB] != rd_ptr[AB]) && (wr_ptr[AB-1:0] == rd_ptr[AB-1:0]);

endmodule

// File: rtl/jtcps1_dwnld_sched.sv
// Write scheduler between the ROM-download decoder and the SDRAM programming port.
// Optional build macro: JTCPS1_DWNLD_SUM_EN enables the running byte checksum.
//
//  state | meaning
//  IDLE  | no request on the port; picks the FIFO head or signals end of download
//  ISSUE | first cycle of a request, timeout counter cleared, ack not yet accepted
//  WAIT  | request held until sdram_ack or timeout, then the entry is popped
//  DONE  | one-cycle dwnld_done pulse
module jtcps1_dwnld_sched
    import jtcps1_dwnld_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 22,
    parameter int TIMEOUT = 1023
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          in_we,
    input  logic [AW-1:0] in_addr,
    input  logic [7:0]    in_data,
    input  logic [1:0]    in_mask,
    input  logic [1:0]    in_bank,
    output logic          dwnld_busy,
    output logic          sdram_we,
    output logic [AW-1:0] sdram_addr,
    output logic [7:0]    sdram_data,
    output logic [1:0]    sdram_mask,
    output logic [1:0]    sdram_bank,
    input  logic          sdram_ack,
    output logic          dwnld_done,
    output logic          ovf_err,
    output logic          tmo_err,
    output logic [15:0]   chksum
);

    localparam int EW = entry_w(AW);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_st_e     state;
    logic [TW-1:0] timer;
    logic [EW-1:0] fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          ack_ok;
    logic          tmo_hit;
    logic          dl_q;
    logic          dl_rise;
    logic          dl_seen;

    assign ack_ok     = (state == ST_WAIT) && sdram_ack;
    assign tmo_hit    = (state == ST_WAIT) && !sdram_ack && (timer == TW'(TIMEOUT));
    assign pop        = ack_ok || tmo_hit;
    assign push       = in_we && (!fifo_full || pop);
    assign count_next = fifo_count + CW'(push) - CW'(pop);
    assign dl_rise    = downloading && !dl_q;

    jtcps1_dwnld_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_bank, in_mask, in_data, in_addr}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // request sequencing; the IDLE cycle after a pop is the one-cycle request gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            sdram_we   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            sdram_mask <= '0;
            sdram_bank <= '0;
            dwnld_done <= 1'b0;
        end else begin
            dwnld_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= ST_ISSUE;
                        sdram_we <= 1'b1;
                        {sdram_bank, sdram_mask, sdram_data, sdram_addr} <= fifo_dout;
                    end else if (!downloading && dl_seen) begin
                        state      <= ST_DONE;
                        dwnld_done <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pop) begin
                        sdram_we <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // remembers that a download was in progress so its end is reported once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_seen <= 1'b0;
        end else if (downloading) begin
            dl_seen <= 1'b1;
        end else if (state == ST_IDLE && fifo_empty) begin
            dl_seen <= 1'b0;
        end
    end

    // sticky error flags, cleared when a new download starts, plus source back-pressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q       <= 1'b0;
            ovf_err    <= 1'b0;
            tmo_err    <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            dl_q       <= downloading;
            dwnld_busy <= (count_next >= CW'(DEPTH - 1));
            if (dl_rise) begin
                ovf_err <= 1'b0;
                tmo_err <= 1'b0;
            end else begin
                if (in_we && !push) ovf_err <= 1'b1;
                if (tmo_hit)        tmo_err <= 1'b1;
            end
        end
    end

`ifdef JTCPS1_DWNLD_SUM_EN
    logic [15:0] sum_r;

    // byte checksum over acknowledged writes only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= '0;
        end else if (dl_rise) begin
            sum_r <= '0;
        end else if (ack_ok) begin
            sum_r <= sum_r + {8'd0, sdram_data};
        end
    end

    assign chksum = sum_r;
`else
    assign chksum = 16'd0;
`endif

endmodule

// File: tb/tb_jtcps1_dwnld_sched.sv
// Self-checking bench for jtcps1_dwnld_sched: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_jtcps1_dwnld_sched;

    localparam int DEPTH   = 4;
    localparam int AW      = 22;
    localparam int TIMEOUT = 1023;

`ifdef JTCPS1_DWNLD_SUM_EN
    localparam logic [15:0] T6_EXP = 16'h0200;
`else
    localparam logic [15:0] T6_EXP = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic          in_we = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [7:0]    in_data = '0;
    logic [1:0]    in_mask = '0;
    logic [1:0]    in_bank = '0;
    logic          sdram_ack = 1'b0;
    logic          dwnld_busy, sdram_we, dwnld_done, ovf_err, tmo_err;
    logic [AW-1:0] sdram_addr;
    logic [7:0]    sdram_data;
    logic [1:0]    sdram_mask, sdram_bank;
    logic [15:0]   chksum;

    always #5 clk = ~clk;

    jtcps1_dwnld_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .downloading(downloading), .in_we(in_we),
        .in_addr(in_addr), .in_data(in_data), .in_mask(in_mask), .in_bank(in_bank),
        .dwnld_busy(dwnld_busy), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_data(sdram_data), .sdram_mask(sdram_mask), .sdram_bank(sdram_bank),
        .sdram_ack(sdram_ack), .dwnld_done(dwnld_done), .ovf_err(ovf_err),
        .tmo_err(tmo_err), .chksum(chksum)
    );

    typedef struct packed {
        logic [1:0]    bank;
        logic [1:0]    mask;
        logic [7:0]    data;
        logic [AW-1:0] addr;
    } ent_t;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: pending writes in arrival order plus the observable flags
    ent_t        q[$];
    ent_t        m_fields;
    logic        m_we, m_done, m_ovf, m_tmo, m_seen, m_prev_dl;
    int          m_run;
    logic [15:0] m_sum;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fields = '0; m_we = 0; m_done = 0; m_ovf = 0; m_tmo = 0;
        m_seen = 0; m_prev_dl = 0; m_run = 0; m_sum = '0;
    endtask

    // advance one clock: predict from the model, then compare after the edge
    task automatic step();
        logic ackv, pop, accept, nwe, ndone;
        int   qlen;
        ent_t e;
        qlen   = q.size();
        ackv   = sdram_ack && m_we && (m_run >= 2);
        pop    = m_we && (ackv || m_run == TIMEOUT + 2);
        accept = in_we && (qlen < DEPTH || pop);
        nwe    = m_we ? !pop : (qlen > 0 && !m_done);
        ndone  = !m_we && !m_done && qlen == 0 && !downloading && m_seen;
        if (!m_we && nwe) m_fields = q[0];
        if (pop) begin
            e = q.pop_front();
            if (ackv) m_sum = m_sum + {8'd0, e.data};
            else      m_tmo = 1'b1;
        end
        if (accept) q.push_back(ent_t'({in_bank, in_mask, in_data, in_addr}));
        if (in_we && !accept) m_ovf = 1'b1;
        if (downloading && !m_prev_dl) begin
            m_ovf = 1'b0; m_tmo = 1'b0; m_sum = '0;
        end
        if (downloading) m_seen = 1'b1;
        else if (ndone)  m_seen = 1'b0;
        m_prev_dl = downloading;
        m_run  = nwe ? (m_we ? m_run + 1 : 1) : 0;
        m_we   = nwe;
        m_done = ndone;
        @(posedge clk); #1;
        check_val("sdram_we", sdram_we, m_we);
        check_val("dwnld_done", dwnld_done, m_done);
        check_val("dwnld_busy", dwnld_busy, (q.size() >= DEPTH - 1));
        check_val("ovf_err", ovf_err, m_ovf);
        check_val("tmo_err", tmo_err, m_tmo);
`ifdef JTCPS1_DWNLD_SUM_EN
        check_val("chksum", chksum, m_sum);
`else
        check_val("chksum", chksum, 16'd0);
`endif
        if (m_we) check_val("fields", {sdram_bank, sdram_mask, sdram_data, sdram_addr}, m_fields);
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic [7:0] d,
                            input logic [1:0] m, input logic [1:0] b);
        in_we = 1'b1; in_addr = a; in_data = d; in_mask = m; in_bank = b;
        step();
        in_we = 1'b0;
    endtask

    // ack every request on its second high cycle until the model is empty
    task automatic drain(input int max, output int acks);
        logic wprev;
        wprev = 1'b0;
        acks  = 0;
        for (int i = 0; i < max && (q.size() > 0 || m_we); i++) begin
            sdram_ack = sdram_we && wprev;
            wprev     = sdram_we;
            if (sdram_ack) acks++;
            step();
            sdram_ack = 1'b0;
        end
        step();
    endtask

    task automatic apply_reset();
        in_we = 0; sdram_ack = 0; downloading = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [63:0] all_outs();
        return {9'd0, dwnld_busy, sdram_we, sdram_addr, sdram_data, sdram_mask,
                sdram_bank, dwnld_done, ovf_err, tmo_err, chksum};
    endfunction

    initial begin
        int hi, acks, dn;
        logic wprev;

        apply_reset();
        check_val("reset_outs", all_outs(), 64'd0);
        downloading = 1'b1;
        step();

        // single write, acknowledged on its fourth request cycle
        push_one(22'h1234, 8'hA5, 2'b10, 2'd1);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            sdram_ack = sdram_we && (hi == 3);
            if (sdram_we) hi++;
            step();
            sdram_ack = 1'b0;
        end
        check_val("t1_we_cycles", hi, 4);
        check_val("t1_empty", dwnld_busy, 1'b0);

        // fill the FIFO with ack held off, then overflow it once
        for (int k = 0; k < 5; k++) begin
            push_one(22'h100 + k, 8'h11 * (k + 1), 2'(k), 2'(k + 1));
            if (k == 1) check_val("t2_busy_2", dwnld_busy, 1'b0);
            if (k == 2) check_val("t2_busy_3", dwnld_busy, 1'b1);
            if (k == 3) check_val("t2_ovf_4", ovf_err, 1'b0);
            if (k == 4) check_val("t3_ovf_5", ovf_err, 1'b1);
        end
        drain(60, acks);
        check_val("t3_acks", acks, 4);

        // no ack: entry dropped by timeout, next entry issued
        push_one(22'h2000, 8'h33, 2'b00, 2'd2);
        push_one(22'h2001, 8'h44, 2'b01, 2'd3);
        hi = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            if (sdram_we) hi++;
            else if (hi > 0) break;
            step();
        end
        check_val("t4_run", hi, TIMEOUT + 2);
        check_val("t4_tmo", tmo_err, 1'b1);
        drain(20, acks);
        check_val("t4_next", acks, 1);

        // ack on the last wait cycle wins over the timeout
        downloading = 1'b0;
        repeat (3) step();
        downloading = 1'b1;
        step();
        check_val("t4_tmo_clr", tmo_err, 1'b0);
        push_one(22'h2100, 8'h55, 2'b00, 2'd0);
        hi = 0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            if (sdram_we) begin
                hi++;
                sdram_ack = (hi == TIMEOUT + 2);
            end else if (hi > 0) break;
            step();
            sdram_ack = 1'b0;
        end
        check_val("t4_ack_run", hi, TIMEOUT + 2);
        check_val("t4_ack_wins", tmo_err, 1'b0);

        // end of download with two writes still pending
        push_one(22'h3000, 8'h66, 2'b00, 2'd1);
        push_one(22'h3001, 8'h77, 2'b00, 2'd1);
        downloading = 1'b0;
        dn = 0; acks = 0; wprev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sdram_ack = sdram_we && wprev;
            wprev     = sdram_we;
            if (sdram_ack) acks++;
            step();
            sdram_ack = 1'b0;
            if (dwnld_done) dn++;
        end
        check_val("t5_acks", acks, 2);
        check_val("t5_done_once", dn, 1);

        // checksum over FF, FF, 02
        downloading = 1'b1;
        step();
        push_one(22'h4000, 8'hFF, 2'b00, 2'd0);
        push_one(22'h4001, 8'hFF, 2'b00, 2'd0);
        push_one(22'h4002, 8'h02, 2'b00, 2'd0);
        drain(40, acks);
        check_val("t6_chksum", chksum, T6_EXP);

        // random traffic, occasionally ignoring back-pressure
        for (int i = 0; i < 800; i++) begin
            in_we     = dwnld_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            in_addr   = AW'($urandom);
            in_data   = 8'($urandom);
            in_mask   = 2'($urandom);
            in_bank   = 2'($urandom);
            sdram_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        in_we = 1'b0; sdram_ack = 1'b0;
        drain(100, acks);
        check_val("rnd_drained", q.size(), 0);

        // asynchronous reset in the middle of a request
        push_one(22'h5000, 8'h99, 2'b11, 2'd3);
        repeat (3) step();
        check_val("rst_pre_we", sdram_we, 1'b1);
        #3 rst = 1'b1;
        #1 check_val("rst_async_outs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
